// File: rtl/trap_ctrl_pkg.sv
// Shared packages for the trap controller slice.
//   rv32     : base word type and XLEN for the RV32 datapath.
//   saratoga : trap controller FSM state enum, machine CSR addresses and
//              mstatus bit positions.
// Optional feature macro used by this slice: TRAP_CTRL_MTVAL_EN.
package rv32;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word;
endpackage

package saratoga;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_INSERT,
    ST_SETTLE,
    ST_RET
  } trap_ctrl_state_e;

  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
endpackage

// File: rtl/trap_ctrl_if.sv
// Trap request handshake between the trap unit (master) and trap_ctrl (slave).
//   trap_req     : request, held by the trap unit until trap_insert
//   trap_pc      : mtvec-resolved trap destination
//   trap_epc     : faulting / interrupted PC
//   trap_cause   : mcause value (bit 31 = interrupt)
//   trap_val     : mtval value
//   trap_insert  : one-cycle acknowledge from trap_ctrl
interface trap_ctrl_if;
  import rv32::*;

  logic trap_req;
  word  trap_pc;
  word  trap_epc;
  word  trap_cause;
  word  trap_val;
  logic trap_insert;

  modport master (
    output trap_req, trap_pc, trap_epc, trap_cause, trap_val,
    input  trap_insert
  );

  modport slave (
    input  trap_req, trap_pc, trap_epc, trap_cause, trap_val,
    output trap_insert
  );
endinterface

// File: rtl/trap_csr_regs.sv
// Machine trap CSRs: mepc, mcause, mtval, mstatus.MIE and mstatus.MPIE.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_commit + i_commit*     : trap entry commit (epc/cause/val)
//   i_ret                    : MRET return (MIE<=MPIE, MPIE<=1)
//   i_we, i_addr, i_wdata    : CSR instruction write
//   o_mepc/o_mcause/o_mtval  : CSR values
//   o_mie, o_mpie            : mstatus interrupt-enable bits
// Macro TRAP_CTRL_MTVAL_EN: when undefined, mtval has no flops and reads 0.
module trap_csr_regs
  import rv32::*;
  import saratoga::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_commit,
  input  word         i_commitEpc,
  input  word         i_commitCause,
  input  word         i_commitVal,
  input  logic        i_ret,
  input  logic        i_we,
  input  logic [11:0] i_addr,
  input  word         i_wdata,
  output word         o_mepc,
  output word         o_mcause,
  output word         o_mtval,
  output logic        o_mie,
  output logic        o_mpie
);

  word  r_mepc;
  word  r_mcause;
  logic r_mie;
  logic r_mpie;

  // Trap commit, MRET and CSR writes are mutually exclusive by FSM state;
  // the priority order only matters if that ever changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else if (i_commit) begin
      r_mepc   <= i_commitEpc & ~32'h3;
      r_mcause <= i_commitCause;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (i_ret) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (i_we) begin
      case (i_addr)
        CSR_ADDR_MEPC:    r_mepc   <= i_wdata & ~32'h3;
        CSR_ADDR_MCAUSE:  r_mcause <= i_wdata;
        CSR_ADDR_MSTATUS: begin
          r_mie  <= i_wdata[MSTATUS_MIE_BIT];
          r_mpie <= i_wdata[MSTATUS_MPIE_BIT];
        end
        default: ;
      endcase
    end
  end

`ifdef TRAP_CTRL_MTVAL_EN
  word r_mtval;

  // mtval follows the same commit / write precedence as the other CSRs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtval <= '0;
    end else if (i_commit) begin
      r_mtval <= i_commitVal;
    end else if (!i_ret && i_we && (i_addr == CSR_ADDR_MTVAL)) begin
      r_mtval <= i_wdata;
    end
  end

  assign o_mtval = r_mtval;
`else
  logic w_unusedVal;
  assign w_unusedVal = ^i_commitVal;
  assign o_mtval     = '0;
`endif

  assign o_mepc   = r_mepc;
  assign o_mcause = r_mcause;
  assign o_mie    = r_mie;
  assign o_mpie   = r_mpie;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: responder side of the trap request handshake. Captures a
// trap, waits for outstanding data accesses (bounded by DRAIN_MAX), then
// inserts the trap (ack, flush, redirect, CSR commit). Also sequences MRET.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   trapIf (slave)    : trap_req/pc/epc/cause/val in, trap_insert out
//   i_mret            : MRET in Decode, one-cycle pulse
//   i_memBusy         : data bus transaction outstanding
//   i_csrWe/Addr/Wdata: CSR instruction write
//   o_stall           : freeze Fetch/Decode/Execute
//   o_pcRedirect      : load o_redirectPc into fetch PC (pulse)
//   o_flushFetch/Decode/Exec : stage squashes
//   o_mepc/o_mcause/o_mtval, o_mstatusMie/Mpie : CSR state
// Macro TRAP_CTRL_MTVAL_EN: enables mtval capture and writes; otherwise 0.
module trap_ctrl
  import rv32::*;
  import saratoga::*;
#(
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  trapIf,
  input  logic        i_mret,
  input  logic        i_memBusy,
  input  logic        i_csrWe,
  input  logic [11:0] i_csrAddr,
  input  word         i_csrWdata,
  output logic        o_stall,
  output logic        o_pcRedirect,
  output word         o_redirectPc,
  output logic        o_flushFetch,
  output logic        o_flushDecode,
  output logic        o_flushExec,
  output word         o_mepc,
  output word         o_mcause,
  output word         o_mtval,
  output logic        o_mstatusMie,
  output logic        o_mstatusMpie
);

  localparam int CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  trap_ctrl_state_e r_state;
  trap_ctrl_state_e w_nextState;
  logic [CW-1:0]    r_drainCnt;
  word              r_pc;
  word              r_epc;
  word              r_cause;
  word              w_captVal;
  logic             w_insert;
  logic             w_commit;
  logic             w_ret;
  logic             w_csrWe;
  logic             w_capture;

  assign w_capture = !rst && (r_state == ST_IDLE) && trapIf.trap_req;

  // State register and drain counter; the counter only runs while we stay
  // in DRAIN, so it is back at zero whenever DRAIN is entered again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_drainCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == ST_DRAIN) && (w_nextState == ST_DRAIN)) begin
        r_drainCnt <= r_drainCnt + 1'b1;
      end else begin
        r_drainCnt <= '0;
      end
    end
  end

  // Capture the trap payload the cycle the request is accepted, since the
  // source may change its fields once it sees trap_insert.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_epc   <= '0;
      r_cause <= '0;
    end else if (w_capture) begin
      r_pc    <= trapIf.trap_pc;
      r_epc   <= trapIf.trap_epc;
      r_cause <= trapIf.trap_cause;
    end
  end

`ifdef TRAP_CTRL_MTVAL_EN
  word r_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
    end else if (w_capture) begin
      r_val <= trapIf.trap_val;
    end
  end

  assign w_captVal = r_val;
`else
  logic w_unusedTrapVal;
  assign w_unusedTrapVal = ^trapIf.trap_val;
  assign w_captVal       = '0;
`endif

  // Next state and all outputs. Everything is held low during reset so an
  // aborted sequence cannot emit a redirect or commit on its way out.
  always_comb begin
    w_nextState   = r_state;
    o_stall       = 1'b0;
    w_insert      = 1'b0;
    o_pcRedirect  = 1'b0;
    o_redirectPc  = '0;
    o_flushFetch  = 1'b0;
    o_flushDecode = 1'b0;
    o_flushExec   = 1'b0;
    w_commit      = 1'b0;
    w_ret         = 1'b0;
    w_csrWe       = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          // A trap request wins over a simultaneous MRET, which is dropped.
          if (trapIf.trap_req) begin
            o_stall     = 1'b1;
            w_nextState = i_memBusy ? ST_DRAIN : ST_INSERT;
          end else begin
            w_csrWe = i_csrWe;
            if (i_mret) w_nextState = ST_RET;
          end
        end
        ST_DRAIN: begin
          o_stall = 1'b1;
          if (!i_memBusy || (r_drainCnt == CW'(DRAIN_MAX - 1))) begin
            w_nextState = ST_INSERT;
          end
        end
        ST_INSERT: begin
          w_insert      = 1'b1;
          o_pcRedirect  = 1'b1;
          o_stall       = 1'b1;
          o_flushFetch  = 1'b1;
          o_flushDecode = 1'b1;
          o_flushExec   = 1'b1;
          o_redirectPc  = r_pc;
          w_commit      = 1'b1;
          w_nextState   = ST_SETTLE;
        end
        ST_SETTLE: begin
          // The source is still clearing its request; ignore it this cycle.
          w_nextState = ST_IDLE;
        end
        ST_RET: begin
          o_pcRedirect  = 1'b1;
          o_redirectPc  = o_mepc;
          o_flushFetch  = 1'b1;
          o_flushDecode = 1'b1;
          w_ret         = 1'b1;
          w_nextState   = ST_IDLE;
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  assign trapIf.trap_insert = w_insert;

  trap_csr_regs u_csrRegs (
    .clk          (clk),
    .rst          (rst),
    .i_commit     (w_commit),
    .i_commitEpc  (r_epc),
    .i_commitCause(r_cause),
    .i_commitVal  (w_captVal),
    .i_ret        (w_ret),
    .i_we         (w_csrWe),
    .i_addr       (i_csrAddr),
    .i_wdata      (i_csrWdata),
    .o_mepc       (o_mepc),
    .o_mcause     (o_mcause),
    .o_mtval      (o_mtval),
    .o_mie        (o_mstatusMie),
    .o_mpie       (o_mstatusMpie)
  );

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl. Every expected redirect (trap insert or
// MRET return) is queued with its expected cycle when the stimulus is driven
// and popped by a monitor whenever the DUT raises pc_redirect/trap_insert.
// CSR state is compared against a small reference model after each sequence.
module tb_trap_ctrl;
  import rv32::*;

  localparam int DRAIN_MAX = 16;

  typedef struct {
    int   cycle;
    word  pc;
    logic insert;
    logic flushEx;
  } redirect_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mret = 1'b0;
  logic        memBusy = 1'b0;
  logic        csrWe = 1'b0;
  logic [11:0] csrAddr = '0;
  word         csrWdata = '0;
  logic        stall, pcRedirect, flushFetch, flushDecode, flushExec;
  logic        mstatusMie, mstatusMpie;
  word         redirectPc, mepc, mcause, mtval;

  int        totalChecks = 0;
  int        badChecks = 0;
  int        cycleCount = 0;
  redirect_t expQ[$];
  redirect_t obsE;

  word  mMepc = '0, mMcause = '0, mMtval = '0;
  logic mMie = 1'b0, mMpie = 1'b0;

  trap_ctrl_if trapBus();

  trap_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .trapIf       (trapBus),
    .i_mret       (mret),
    .i_memBusy    (memBusy),
    .i_csrWe      (csrWe),
    .i_csrAddr    (csrAddr),
    .i_csrWdata   (csrWdata),
    .o_stall      (stall),
    .o_pcRedirect (pcRedirect),
    .o_redirectPc (redirectPc),
    .o_flushFetch (flushFetch),
    .o_flushDecode(flushDecode),
    .o_flushExec  (flushExec),
    .o_mepc       (mepc),
    .o_mcause     (mcause),
    .o_mtval      (mtval),
    .o_mstatusMie (mstatusMie),
    .o_mstatusMpie(mstatusMpie)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  task automatic checkCsrs(input string tag);
    checkOutput({tag, "_mepc"}, mepc, mMepc);
    checkOutput({tag, "_mcause"}, mcause, mMcause);
    checkOutput({tag, "_mtval"}, mtval, mMtval);
    checkOutput({tag, "_mie"}, mstatusMie, mMie);
    checkOutput({tag, "_mpie"}, mstatusMpie, mMpie);
  endtask

  // Scoreboard consumer: any redirect or insert pulse must match the oldest
  // queued expectation, including the cycle it was due in.
  always @(negedge clk) begin
    if (!rst && (pcRedirect || trapBus.trap_insert)) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_pulse", {30'b0, trapBus.trap_insert, pcRedirect}, 32'd0);
      end else begin
        obsE = expQ.pop_front();
        checkOutput("redir_cycle", 32'(cycleCount), 32'(obsE.cycle));
        checkOutput("redir_valid", pcRedirect, 1);
        checkOutput("redir_pc", redirectPc, obsE.pc);
        checkOutput("redir_insert", trapBus.trap_insert, obsE.insert);
        checkOutput("redir_stall", stall, obsE.insert);
        checkOutput("redir_flush_exec", flushExec, obsE.flushEx);
        checkOutput("redir_flush_fetch", flushFetch, 1);
        checkOutput("redir_flush_decode", flushDecode, 1);
      end
    end
  end

  task automatic applyCsrWrite(input logic [11:0] addr, input word data);
    @(posedge clk); #1;
    csrWe = 1'b1; csrAddr = addr; csrWdata = data;
    @(posedge clk); #1;
    csrWe = 1'b0;
    case (addr)
      12'h341: mMepc = data & ~32'h3;
      12'h342: mMcause = data;
`ifdef TRAP_CTRL_MTVAL_EN
      12'h343: mMtval = data;
`endif
      12'h300: begin mMie = data[3]; mMpie = data[7]; end
      default: ;
    endcase
  endtask

  // Drives one trap request, holding it until the handshake completes.
  // busyCycles: how many cycles mem_busy stays high from the request cycle.
  task automatic applyStimulus(input word pc, input word epc, input word cause, input word val,
                               input int busyCycles, input bit withMret, input bit holdSettle);
    int start;
    int insertCycle;
    redirect_t e;
    @(posedge clk); #1;
    trapBus.trap_req = 1'b1; trapBus.trap_pc = pc; trapBus.trap_epc = epc;
    trapBus.trap_cause = cause; trapBus.trap_val = val;
    memBusy = (busyCycles > 0); mret = withMret;
    start = cycleCount;
    insertCycle = start + ((busyCycles < DRAIN_MAX) ? busyCycles : DRAIN_MAX) + 1;
    e.cycle = insertCycle; e.pc = pc; e.insert = 1'b1; e.flushEx = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    checkOutput("stall_on_req", stall, 1);
    for (int c = start + 1; c <= insertCycle + (holdSettle ? 2 : 1); c++) begin
      @(posedge clk); #1;
      mret = 1'b0;
      if (c >= start + busyCycles) memBusy = 1'b0;
      if (busyCycles > 1 && c == start + 1) begin
        @(negedge clk);
        checkOutput("stall_in_drain", stall, 1);
      end
    end
    trapBus.trap_req = 1'b0;
    memBusy = 1'b0;
    mMepc = epc & ~32'h3;
    mMcause = cause;
`ifdef TRAP_CTRL_MTVAL_EN
    mMtval = val;
`endif
    mMpie = mMie;
    mMie = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic applyMret();
    redirect_t e;
    @(posedge clk); #1;
    mret = 1'b1;
    e.cycle = cycleCount + 1; e.pc = mMepc; e.insert = 1'b0; e.flushEx = 1'b0;
    expQ.push_back(e);
    @(posedge clk); #1;
    mret = 1'b0;
    @(posedge clk); #1;
    mMie = mMpie;
    mMpie = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    trapBus.trap_req = 1'b0; trapBus.trap_pc = '0; trapBus.trap_epc = '0;
    trapBus.trap_cause = '0; trapBus.trap_val = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_redirect", pcRedirect, 0);
    checkOutput("rst_insert", trapBus.trap_insert, 0);
    checkCsrs("rst");

    $display("[TB] trap with memory idle");
    applyCsrWrite(12'h300, 32'h0000_0008);
    checkCsrs("mie_set");
    applyStimulus(32'h80, 32'h100, 32'd2, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    checkCsrs("trap_idle");

    $display("[TB] trap with 5-cycle drain");
    applyStimulus(32'h200, 32'h303, 32'h8000_0007, 32'h1234_5678, 5, 1'b0, 1'b0);
    checkCsrs("trap_drain");

    $display("[TB] trap with stuck memory");
    applyStimulus(32'h400, 32'h50C, 32'd5, 32'hCAFE_0001, 40, 1'b0, 1'b0);
    checkCsrs("trap_timeout");

    $display("[TB] mret return");
    applyCsrWrite(12'h341, 32'h204);
    applyCsrWrite(12'h300, 32'h0000_0080);
    checkCsrs("pre_mret");
    applyMret();
    checkCsrs("mret");

    $display("[TB] trap and mret together, request held through settle");
    applyStimulus(32'h600, 32'h7F1, 32'd11, 32'h0000_00AA, 0, 1'b1, 1'b1);
    checkCsrs("trap_mret");

    $display("[TB] reset during drain");
    @(posedge clk); #1;
    trapBus.trap_req = 1'b1; trapBus.trap_pc = 32'h900; trapBus.trap_epc = 32'h904;
    trapBus.trap_cause = 32'd3; memBusy = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("drain_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1; trapBus.trap_req = 1'b0; memBusy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mMepc = '0; mMcause = '0; mMtval = '0; mMie = 1'b0; mMpie = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_stall", stall, 0);
    checkCsrs("post_rst");
    repeat (4) @(posedge clk);

    $display("[TB] CSR writes");
    applyCsrWrite(12'h341, 32'h1003);
    applyCsrWrite(12'h343, 32'h0000_0ABC);
    applyCsrWrite(12'h342, 32'h8000_0003);
    applyCsrWrite(12'h305, 32'hFFFF_FFFF);
    checkCsrs("csr_wr");

    repeat (4) @(posedge clk);
    checkOutput("leftover_expect", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
